// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the PIO polling master.
// Holds the FSM state encoding, the slave register offset and the interval timer width helper.
package pio_poll_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2,
      EMIT    = 2'd3
   } state_t;

   localparam int unsigned PIO_DATA_OFFSET = 0;

   // Width needed to hold POLL_INTERVAL-1; never narrower than one bit.
   function automatic int unsigned timer_width(input int unsigned interval);
      return (interval < 2) ? 1 : $clog2(interval);
   endfunction

endpackage

// File: rtl/poll_interval_timer.sv
// Loadable down-counter used to pace polls; load wins over decrement.
// The zero flag marks the last idle cycle before a read is issued.
module poll_interval_timer #(
   parameter int unsigned          WIDTH  = 4,
   parameter logic [WIDTH-1:0]     RELOAD = '1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= RELOAD;
      end else if (load) begin
         count <= RELOAD;
      end else if (dec) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that polls a read-only PIO register and streams
// each changed value (and the first value after reset) to downstream logic.
module pio_poll_master
   import pio_poll_pkg::*;
#(
   parameter int unsigned POLL_INTERVAL = 16,
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned ADDR_W        = 2,
   parameter int unsigned CNT_W         = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic [31:0]       avm_readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  change_count
);

   localparam int unsigned      TMR_W      = timer_width(POLL_INTERVAL);
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_INTERVAL - 1);

   state_t            state;
   logic [DATA_W-1:0] last_value;
   logic [DATA_W-1:0] sample;
   logic              have_sample;
   logic              tmr_load;
   logic              tmr_dec;
   logic              tmr_zero;

   assign sample = avm_readdata[DATA_W-1:0];

   generate
      if (DATA_W < 32) begin : g_unused_upper
         logic unused_readdata;
         assign unused_readdata = ^avm_readdata[31:DATA_W];
      end
   endgenerate

   // Any state other than an enabled IDLE keeps the timer primed, so every
   // IDLE entry starts a fresh interval.
   always_comb begin
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      if (state == IDLE) begin
         if (!enable) begin
            tmr_load = 1'b1;
         end else if (!tmr_zero) begin
            tmr_dec = 1'b1;
         end
      end else begin
         tmr_load = 1'b1;
      end
   end

   poll_interval_timer #(
      .WIDTH  (TMR_W),
      .RELOAD (TMR_RELOAD)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (tmr_load),
      .dec     (tmr_dec),
      .zero    (tmr_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         avm_read     <= 1'b0;
         avm_address  <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         change_count <= '0;
         last_value   <= '0;
         have_sample  <= 1'b0;
      end else begin
         avm_address <= ADDR_W'(PIO_DATA_OFFSET);
         case (state)
            IDLE: begin
               if (enable && tmr_zero) begin
                  avm_read <= 1'b1;
                  state    <= READ;
               end
            end
            READ: begin
               avm_read <= 1'b0;
               state    <= CAPTURE;
            end
            // Slave data lands one cycle after the address, i.e. in this state.
            CAPTURE: begin
               if (!have_sample || (sample != last_value)) begin
                  last_value  <= sample;
                  have_sample <= 1'b1;
                  out_data    <= sample;
                  out_valid   <= 1'b1;
                  if (change_count != '1) begin
                     change_count <= change_count + 1'b1;
                  end
                  state <= EMIT;
               end else begin
                  state <= IDLE;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
